// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane stores plus an MMIO page
// holding a buffered 8N1 UART transmitter and a free-running cycle counter.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line high; pops the next byte when FIFO has data
// S_START | start bit (low) for BAUD_DIV cycles
// S_DATA  | eight data bits, LSB first, BAUD_DIV cycles each
// S_STOP  | stop bit (high) for BAUD_DIV cycles
module dmem_responder #(
  parameter int              XLEN      = 32,
  parameter int              MEM_WORDS = 1024,
  parameter int              TX_DEPTH  = 8,
  parameter int              BAUD_DIV  = 868,
  parameter logic [XLEN-1:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_wmask,
  input  logic            dmem_we,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            uart_tx,
  output logic            tx_busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(TX_DEPTH);
  localparam logic [XLEN-1:0] MASK_BYTE = XLEN'(32'h0000_00FF);
  localparam logic [XLEN-1:0] MASK_HALF = XLEN'(32'h0000_FFFF);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic            is_mmio;
  logic [7:0]      offset;
  logic [AW-1:0]   word_idx;
  logic [1:0]      lane;
  logic [3:0]      size_be;
  logic [3:0]      wr_be;
  logic [XLEN-1:0] wr_data;
  logic            ram_we;

  logic [XLEN-1:0] mem [MEM_WORDS];

  logic [7:0]      fifo_mem [TX_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, ovf;
  logic            push_req, push, pop, status_wr;
  logic [XLEN-1:0] cycle_cnt;

  state_t          state;
  logic [7:0]      shift;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic            active;

  assign is_mmio  = dmem_addr >= MMIO_BASE;
  assign offset   = dmem_addr[7:0];
  assign word_idx = dmem_addr[AW+1:2];
  assign lane     = dmem_addr[1:0];

  always_comb begin
    size_be = 4'b1111;
    if (dmem_wmask == MASK_BYTE)      size_be = 4'b0001;
    else if (dmem_wmask == MASK_HALF) size_be = 4'b0011;
  end

  // Lanes shifted past byte 3 fall off the top: no spill into the next word.
  assign wr_be   = size_be << lane;
  assign wr_data = dmem_wdata << {lane, 3'b000};
  assign ram_we  = dmem_we & ~is_mmio & reset_n;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  assign full      = count == DEPTH_CNT;
  assign empty     = count == '0;
  assign push_req  = dmem_we & is_mmio & (offset == 8'h00);
  assign status_wr = dmem_we & is_mmio & (offset == 8'h04);
  assign push      = push_req & ~full;
  assign pop       = (state == S_IDLE) & ~empty;
  assign active    = state != S_IDLE;
  assign tx_busy   = active | ~empty;

  always_comb begin
    dmem_rdata = '0;
    if (is_mmio) begin
      case (offset)
        8'h04:   dmem_rdata = {{(XLEN-4){1'b0}}, ovf, active, full, empty};
        8'h08:   dmem_rdata = cycle_cnt;
        default: dmem_rdata = '0;
      endcase
    end else begin
      dmem_rdata = mem[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dmem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + XLEN'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Overflow is judged on the pre-edge fullness, even if a pop frees a slot.
      if (push_req && full) ovf <= 1'b1;
      else if (status_wr)   ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      uart_tx  <= 1'b1;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift    <= fifo_mem[rd_ptr];
            baud_cnt <= '0;
            uart_tx  <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array RAM model, posedge-count cycle model,
// and an independent UART receiver checking frames against pushed bytes.
module tb_dmem_responder;
  localparam int          MEM_WORDS = 256;
  localparam int          TX_DEPTH  = 8;
  localparam int          BAUD_DIV  = 4;
  localparam logic [31:0] MMIO      = 32'hFFFF_FF00;
  localparam logic [31:0] M_B = 32'h0000_00FF;
  localparam logic [31:0] M_H = 32'h0000_FFFF;
  localparam logic [31:0] M_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_wmask = '0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_rdata;
  logic        uart_tx;
  logic        tx_busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram_m [MEM_WORDS][4];
  logic [31:0] cyc_m;
  logic [7:0]  rx_q [$];
  logic [7:0]  rx_byte;

  always #5 clk = ~clk;

  dmem_responder #(
    .XLEN(32), .MEM_WORDS(MEM_WORDS), .TX_DEPTH(TX_DEPTH),
    .BAUD_DIV(BAUD_DIV), .MMIO_BASE(MMIO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_m <= '0;
    else          cyc_m <= cyc_m + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [31:0] m);
    int sz;
    int idx;
    int off;
    sz  = (m == M_B) ? 1 : (m == M_H) ? 2 : 4;
    idx = int'((a >> 2) % MEM_WORDS);
    off = int'(a % 4);
    for (int k = 0; k < sz; k++) if (off + k < 4) ram_m[idx][off + k] = d[8*k +: 8];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int idx;
    idx = int'((a >> 2) % MEM_WORDS);
    return {ram_m[idx][3], ram_m[idx][2], ram_m[idx][1], ram_m[idx][0]};
  endfunction

  // Commits on the next posedge; returns at the following negedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    dmem_addr = a; dmem_wdata = d; dmem_wmask = m; dmem_we = 1'b1;
    @(negedge clk);
    dmem_we = 1'b0;
  endtask

  task automatic ram_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    store(a, d, m);
    model_store(a, d, m);
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    dmem_addr = a; dmem_we = 1'b0;
    #1;
    d = dmem_rdata;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    peek(a, d);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (tx_busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(tx_busy), 32'd0);
  endtask

  // Independent receiver: samples mid-bit, LSB first.
  initial begin
    forever begin
      @(negedge uart_tx);
      repeat (BAUD_DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD_DIV) @(negedge clk);
        rx_byte[i] = uart_tx;
      end
      repeat (BAUD_DIV) @(negedge clk);
      chk("rx_stop_bit", 32'(uart_tx), 32'd1);
      rx_q.push_back(rx_byte);
    end
  end

  initial begin
    logic [31:0] d, a, w, m;
    logic [7:0]  exp_q [$];
    logic [9:0]  frame;
    int          n;

    repeat (3) @(negedge clk);
    peek(MMIO + 32'h4, d);  chk("rst_status", d, 32'h1);
    peek(MMIO + 32'h8, d);  chk("rst_cycle", d, 32'h0);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    store(MMIO, 32'h77, M_B);
    peek(MMIO + 32'h4, d);  chk("rst_push_ignored", d, 32'h1);

    @(negedge clk);
    reset_n = 1'b1;
    peek(MMIO + 32'h8, d);  chk("cycle_at_release", d, 32'd0);
    @(negedge clk);
    peek(MMIO + 32'h8, d);  chk("cycle_first_edge", d, 32'd1);

    // RAM directed cases
    ram_store(32'h10, 32'hDEAD_BEEF, M_W);
    ram_store(32'h12, 32'h55, M_B);
    rd(32'h10, d);          chk("sb_lane2", d, 32'hDE55_BEEF);
    ram_store(32'h14, 32'h0, M_W);
    ram_store(32'h13, 32'h1234, M_H);
    rd(32'h10, d);          chk("sh_lane3_drop", d, 32'h3455_BEEF);
    rd(32'h14, d);          chk("sh_no_spill", d, 32'h0);
    ram_store(32'h0, 32'hCAFE_F00D, M_W);
    ram_store(MEM_WORDS * 4, 32'h0123_4567, M_W);
    rd(32'h0, d);           chk("alias_word0", d, 32'h0123_4567);
    ram_store(32'h20, 32'hA1B2_C3D4, 32'h00FF_00FF);
    rd(32'h20, d);          chk("odd_mask_word", d, 32'hA1B2_C3D4);
    ram_store(32'h22, 32'h1122_3344, M_W);
    rd(32'h20, d);          chk("sw_misaligned", d, 32'h3344_C3D4);
    ram_store(32'd192 * 4, 32'h5A5A_5A5A, M_W);
    ram_store(32'hFFFF_FEFC, 32'h1357_9BDF, M_W);
    rd(32'hFFFF_FEFC, d);   chk("below_mmio_ram", d, model_word(32'hFFFF_FEFC));

    // Read during write returns the old word
    @(negedge clk);
    dmem_addr = 32'h20; dmem_wdata = 32'h5555_5555; dmem_wmask = M_W; dmem_we = 1'b1;
    #1;                     chk("rdw_old", dmem_rdata, 32'h3344_C3D4);
    @(negedge clk);
    dmem_we = 1'b0;
    model_store(32'h20, 32'h5555_5555, M_W);
    #1;                     chk("rdw_new", dmem_rdata, 32'h5555_5555);

    // Randomised RAM traffic over words 0..15 with random aliasing upper bits
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      ram_store(32'(i) * 4, w, M_W);
    end
    for (int i = 0; i < 300; i++) begin
      a = ($urandom & 32'h7FFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 2) == 0) begin
        rd(a, d);
        chk("rand_ram_read", d, model_word(a));
      end else begin
        case ($urandom_range(0, 3))
          0:       m = M_B;
          1:       m = M_H;
          2:       m = M_W;
          default: m = $urandom;
        endcase
        w = $urandom;
        ram_store(a, w, m);
      end
    end

    // MMIO misc
    rd(MMIO + 32'h8, d);    chk("cycle_a", d, cyc_m);
    store(MMIO + 32'h8, 32'h0, M_W);
    rd(MMIO + 32'h8, d);    chk("cycle_write_ignored", d, cyc_m);
    rd(MMIO, d);            chk("txdata_reads_0", d, 32'h0);
    rd(MMIO + 32'hC, d);    chk("unmapped_0c", d, 32'h0);
    rd(MMIO + 32'hFC, d);   chk("unmapped_fc", d, 32'h0);
    store(MMIO + 32'hC, 32'hFF, M_W);
    rd(MMIO + 32'h4, d);    chk("unmapped_write_ignored", d, 32'h1);

    // Single frame, bit-exact
    @(negedge clk);
    store(MMIO, 32'hA5, M_B);
    chk("push_busy", 32'(tx_busy), 32'd1);
    chk("push_line_idle", 32'(uart_tx), 32'd1);
    peek(MMIO + 32'h4, d);  chk("status_one_queued", d, 32'h0);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10 * BAUD_DIV; i++) begin
      @(negedge clk);
      chk("a5_bit", 32'(uart_tx), 32'(frame[i / BAUD_DIV]));
      chk("a5_busy", 32'(tx_busy), 32'd1);
    end
    @(negedge clk);
    chk("a5_done_line", 32'(uart_tx), 32'd1);
    chk("a5_done_busy", 32'(tx_busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("a5_rx_count", 32'(rx_q.size()), 32'd1);
    chk("a5_rx_byte", 32'(rx_q[0]), 32'hA5);
    rx_q.delete();

    // Ten back-to-back pushes into an 8-deep FIFO
    for (int i = 0; i < 10; i++) begin
      store(MMIO, 32'h30 + 32'(i), M_B);
      if (i == 1) begin
        peek(MMIO + 32'h4, d);
        chk("push_pop_same_cycle", d, 32'h4);
      end
    end
    peek(MMIO + 32'h4, d);  chk("status_ovf_full", d, 32'h0E);
    store(MMIO + 32'h4, 32'h0, M_W);
    peek(MMIO + 32'h4, d);  chk("status_ovf_cleared", d, 32'h06);
    wait_idle("ovf_drain_timeout");
    repeat (5) @(negedge clk);
    chk("ovf_rx_count", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) chk("ovf_rx_order", 32'(rx_q[i]), 32'h30 + 32'(i));
    rx_q.delete();
    rd(MMIO + 32'h4, d);    chk("status_drained", d, 32'h1);

    // Random bursts of 1..3 bytes with random gaps
    exp_q.delete();
    for (int g = 0; g < 6; g++) begin
      wait_idle("burst_idle_timeout");
      @(negedge clk);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        w = 32'($urandom_range(0, 255));
        exp_q.push_back(w[7:0]);
        store(MMIO, w, M_B);
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    wait_idle("burst_drain_timeout");
    repeat (5) @(negedge clk);
    chk("burst_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk("burst_rx_byte", 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();

    // Reset in the middle of a frame
    ram_store(32'h40, 32'h1111_1111, M_W);
    store(MMIO, 32'h5A, M_B);
    repeat (12) @(negedge clk);
    chk("mid_frame_busy", 32'(tx_busy), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_line_high", 32'(uart_tx), 32'd1);
    chk("abort_busy_low", 32'(tx_busy), 32'd0);
    peek(MMIO + 32'h4, d);  chk("abort_status", d, 32'h1);
    peek(MMIO + 32'h8, d);  chk("abort_cycle", d, 32'h0);
    @(negedge clk);
    store(32'h40, 32'h2222_2222, M_W);
    store(MMIO, 32'h66, M_B);
    peek(MMIO + 32'h4, d);  chk("in_reset_push_ignored", d, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    peek(MMIO + 32'h8, d);  chk("rel_cycle_0", d, 32'h0);
    @(negedge clk);
    peek(MMIO + 32'h8, d);  chk("rel_cycle_1", d, 32'h1);
    rd(32'h40, d);          chk("in_reset_store_ignored", d, 32'h1111_1111);
    rd(32'd192 * 4, d);     chk("mmio_no_ram_write", d, 32'h5A5A_5A5A);
    repeat (60) @(negedge clk);
    rx_q.delete();

    store(MMIO, 32'hC3, M_B);
    wait_idle("post_reset_timeout");
    repeat (5) @(negedge clk);
    chk("post_reset_rx_count", 32'(rx_q.size()), 32'd1);
    chk("post_reset_rx_byte", 32'(rx_q[0]), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
